// File: rtl/i2c_nco_pkg.sv
// Shared types and constants for the I2C write-only master that programs the NCO slave.
package i2c_nco_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        CTRL,
        CTRL_ACK,
        FREQ,
        FREQ_ACK,
        DUTY,
        DUTY_ACK,
        STOP
    } state_t;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_WAVE_LO = 1;
    localparam int CTRL_DUTY    = 3;
    localparam int CTRL_FREQ    = 4;

    localparam int FREQ_BYTES = 8;
    localparam int DUTY_BYTES = 2;

    function automatic logic is_data_state(input state_t s);
        return (s == ADDR) || (s == CTRL) || (s == FREQ) || (s == DUTY);
    endfunction

    function automatic logic is_ack_state(input state_t s);
        return (s == ADDR_ACK) || (s == CTRL_ACK) || (s == FREQ_ACK) || (s == DUTY_ACK);
    endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// SCL bit-slot timing: a quarter-period counter driving a 4-phase sequencer.
module i2c_bit_timer #(
    parameter int QUARTER = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_run,
    output logic [1:0] o_phase,
    output logic       o_phase_tick,
    output logic       o_bit_end
);

    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QUARTER - 1);

    logic [QW-1:0] r_qcnt;
    logic [1:0]    r_phase;

    // Held at zero while idle so every transaction starts on a fresh phase 0.
    always_ff @(posedge clk) begin
        if (!reset || !i_run) begin
            r_qcnt  <= '0;
            r_phase <= '0;
        end else if (r_qcnt == QMAX) begin
            r_qcnt  <= '0;
            r_phase <= r_phase + 2'd1;
        end else begin
            r_qcnt  <= r_qcnt + QW'(1);
        end
    end

    assign o_phase      = r_phase;
    assign o_phase_tick = i_run && (r_qcnt == QMAX);
    assign o_bit_end    = o_phase_tick && (r_phase == 2'd3);

endmodule

// File: rtl/i2c_nco_master.sv
// I2C write-only master: START, address+W, control byte, optional frequency/duty payload, STOP.
module i2c_nco_master
    import i2c_nco_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'b1110101,
    parameter int         QUARTER    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_ctrl,
    input  logic [63:0] cmd_freq,
    input  logic [15:0] cmd_duty,
    output logic        busy,
    output logic        done,
    output logic        ack_error,
    output logic        scl,
    inout  wire         sda
);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_ctrl;
    logic [63:0] r_freq;
    logic [15:0] r_duty;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  r_byte_cnt;
    logic        r_nack;
    logic        r_ack_err;
    logic        r_sda_s1;
    logic        r_sda_s2;

    logic [1:0]  w_phase;
    logic        w_phase_tick;
    logic        w_bit_end;
    logic        w_load;
    logic [7:0]  w_load_byte;
    logic [2:0]  w_byte_cnt_nxt;
    logic        w_sda_low;
    logic        w_accept;
    logic        w_ack_sample;

    function automatic logic [7:0] freq_byte(input logic [63:0] f, input logic [2:0] idx);
        return f[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] duty_byte(input logic [15:0] d, input logic idx);
        return idx ? d[15:8] : d[7:0];
    endfunction

    i2c_bit_timer #(.QUARTER(QUARTER)) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_run        (r_state != IDLE),
        .o_phase      (w_phase),
        .o_phase_tick (w_phase_tick),
        .o_bit_end    (w_bit_end)
    );

    assign w_accept     = (r_state == IDLE) && cmd_valid;
    assign w_ack_sample = is_ack_state(r_state) && (w_phase == 2'd2) && w_phase_tick;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Every branch that enters a byte state also selects the byte to load into the shifter.
    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        w_load_byte    = 8'h00;
        w_byte_cnt_nxt = r_byte_cnt;
        case (r_state)
            IDLE:  if (cmd_valid) w_next_state = START;
            START: if (w_bit_end) begin
                w_next_state = ADDR;
                w_load       = 1'b1;
                w_load_byte  = {SLAVE_ADDR, 1'b0};
            end
            ADDR:  if (w_bit_end && r_bit_cnt == 3'd0) w_next_state = ADDR_ACK;
            CTRL:  if (w_bit_end && r_bit_cnt == 3'd0) w_next_state = CTRL_ACK;
            FREQ:  if (w_bit_end && r_bit_cnt == 3'd0) w_next_state = FREQ_ACK;
            DUTY:  if (w_bit_end && r_bit_cnt == 3'd0) w_next_state = DUTY_ACK;
            ADDR_ACK: if (w_bit_end) begin
                if (r_nack) begin
                    w_next_state = STOP;
                end else begin
                    w_next_state = CTRL;
                    w_load       = 1'b1;
                    w_load_byte  = r_ctrl;
                end
            end
            CTRL_ACK: if (w_bit_end) begin
                if (r_nack) begin
                    w_next_state = STOP;
                end else if (r_ctrl[CTRL_FREQ]) begin
                    w_next_state   = FREQ;
                    w_load         = 1'b1;
                    w_byte_cnt_nxt = 3'(FREQ_BYTES - 1);
                    w_load_byte    = freq_byte(r_freq, 3'(FREQ_BYTES - 1));
                end else if (r_ctrl[CTRL_DUTY]) begin
                    w_next_state   = DUTY;
                    w_load         = 1'b1;
                    w_byte_cnt_nxt = 3'(DUTY_BYTES - 1);
                    w_load_byte    = duty_byte(r_duty, 1'b1);
                end else begin
                    w_next_state = STOP;
                end
            end
            FREQ_ACK: if (w_bit_end) begin
                if (r_nack) begin
                    w_next_state = STOP;
                end else if (r_byte_cnt != 3'd0) begin
                    w_next_state   = FREQ;
                    w_load         = 1'b1;
                    w_byte_cnt_nxt = r_byte_cnt - 3'd1;
                    w_load_byte    = freq_byte(r_freq, r_byte_cnt - 3'd1);
                end else if (r_ctrl[CTRL_DUTY]) begin
                    w_next_state   = DUTY;
                    w_load         = 1'b1;
                    w_byte_cnt_nxt = 3'(DUTY_BYTES - 1);
                    w_load_byte    = duty_byte(r_duty, 1'b1);
                end else begin
                    w_next_state = STOP;
                end
            end
            DUTY_ACK: if (w_bit_end) begin
                if (r_nack) begin
                    w_next_state = STOP;
                end else if (r_byte_cnt != 3'd0) begin
                    w_next_state   = DUTY;
                    w_load         = 1'b1;
                    w_byte_cnt_nxt = r_byte_cnt - 3'd1;
                    w_load_byte    = duty_byte(r_duty, 1'b0);
                end else begin
                    w_next_state = STOP;
                end
            end
            STOP:    if (w_bit_end) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        scl       = 1'b1;
        w_sda_low = 1'b0;
        busy      = (r_state != IDLE);
        done      = 1'b0;
        case (r_state)
            IDLE: ;
            START: begin
                scl       = (w_phase < 2'd2);
                w_sda_low = (w_phase != 2'd0);
            end
            STOP: begin
                scl       = (w_phase != 2'd0);
                w_sda_low = (w_phase < 2'd2);
                done      = w_bit_end;
            end
            default: begin
                scl       = w_phase[1];
                w_sda_low = is_data_state(r_state) && !r_shift[7];
            end
        endcase
    end

    assign sda       = w_sda_low ? 1'b0 : 1'bz;
    assign ack_error = r_ack_err;

    // Payload shadows and shifter carry data only, so they are left out of reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ctrl <= cmd_ctrl;
            r_freq <= cmd_freq;
            r_duty <= cmd_duty;
        end
        if (w_load) r_shift <= w_load_byte;
        else if (w_bit_end && is_data_state(r_state)) r_shift <= {r_shift[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 3'd0;
            r_nack     <= 1'b0;
            r_ack_err  <= 1'b0;
            r_sda_s1   <= 1'b1;
            r_sda_s2   <= 1'b1;
        end else begin
            r_sda_s1   <= sda;
            r_sda_s2   <= r_sda_s1;
            r_byte_cnt <= w_byte_cnt_nxt;
            if (w_load) r_bit_cnt <= 3'd7;
            else if (w_bit_end && is_data_state(r_state)) r_bit_cnt <= r_bit_cnt - 3'd1;
            if (w_ack_sample) r_nack <= r_sda_s2;
            if (w_accept) r_ack_err <= 1'b0;
            else if (w_ack_sample && r_sda_s2) r_ack_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_nco_master.sv
// Bench for i2c_nco_master: bus-level slot model checked every cycle plus a behavioural NCO slave.
`timescale 1ns/1ps
module tb_i2c_nco_master;

    localparam int Q        = 5;
    localparam int SLOT_CLK = 4 * Q;
    localparam int K_START  = 0;
    localparam int K_BIT    = 1;
    localparam int K_ACK    = 2;
    localparam int K_STOP   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_ctrl = 8'h00;
    logic [63:0] cmd_freq = 64'h0;
    logic [15:0] cmd_duty = 16'h0;
    logic        busy, done, ack_error, scl;
    wire         sda;
    logic        slv_low = 1'b0;

    pullup (sda);
    assign sda = slv_low ? 1'b0 : 1'bz;

    i2c_nco_master #(.SLAVE_ADDR(7'b1110101), .QUARTER(Q)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ctrl  (cmd_ctrl),
        .cmd_freq  (cmd_freq),
        .cmd_duty  (cmd_duty),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error),
        .scl       (scl),
        .sda       (sda)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected bus as a list of bit slots
    int  slot_kind[$];
    bit  slot_val[$];
    int  nack_slot = -1;
    bit  mdl_active = 1'b0;
    bit  chk_en = 1'b0;
    bit  mdl_ack_err = 1'b0;
    int  tcyc = 0;
    int  done_len = -1;

    always @(negedge clk) begin
        if (chk_en) begin
            if (mdl_active) begin
                int s, p, kind;
                bit val, sda_chk, ack_chk;
                logic e_scl, e_sda, e_done, e_ack;
                s = tcyc / SLOT_CLK;
                p = (tcyc / Q) % 4;
                kind = slot_kind[s];
                val = slot_val[s];
                e_done = (tcyc == slot_kind.size() * SLOT_CLK - 1);
                case (kind)
                    K_START: begin e_scl = (p < 2);  e_sda = (p == 0); sda_chk = 1'b1;     end
                    K_STOP:  begin e_scl = (p >= 1); e_sda = (p >= 2); sda_chk = 1'b1;     end
                    default: begin e_scl = (p >= 2); e_sda = val;      sda_chk = (p >= 1); end
                endcase
                ack_chk = (nack_slot < 0) || (s != nack_slot);
                e_ack = (nack_slot >= 0) && (s > nack_slot);
                checks++;
                if (scl !== e_scl || busy !== 1'b1 || done !== e_done ||
                    (sda_chk && sda !== e_sda) || (ack_chk && ack_error !== e_ack)) begin
                    errors++;
                    $display("FAIL bus t=%0d slot=%0d ph=%0d: got scl=%b sda=%b busy=%b done=%b ack_error=%b, want scl=%b sda=%b busy=1 done=%b ack_error=%b",
                             tcyc, s, p, scl, sda, busy, done, ack_error, e_scl, e_sda, e_done, e_ack);
                end
                if (done === 1'b1) done_len = tcyc + 1;
                tcyc++;
                if (tcyc == slot_kind.size() * SLOT_CLK) mdl_active = 1'b0;
            end else begin
                checks++;
                if ({scl, sda, busy, done, ack_error} !== {1'b1, 1'b1, 1'b0, 1'b0, mdl_ack_err}) begin
                    errors++;
                    $display("FAIL idle: got scl=%b sda=%b busy=%b done=%b ack_error=%b, want 1 1 0 0 %b",
                             scl, sda, busy, done, ack_error, mdl_ack_err);
                end
            end
        end
    end

    // Behavioural NCO slave: decodes START/STOP/bits from the pins, ACKs when addressed
    logic [6:0]  slv_addr = 7'h75;
    logic        s_prev_scl = 1'b1, s_prev_sda = 1'b1;
    bit          s_in = 1'b0, s_acking = 1'b0, s_addressed = 1'b0;
    int          s_bitn = 0, s_bus_bytes = 0, s_rx_last = 0;
    logic [7:0]  s_sh = 8'h00;
    logic [7:0]  s_rx[$];
    logic        nco_enable = 1'b0;
    logic [1:0]  nco_wave = 2'b00;
    logic [63:0] nco_freq = 64'h0;
    logic [15:0] nco_duty = 16'h0;

    always @(negedge clk) begin
        logic cur_scl, cur_sda;
        logic [7:0] c;
        logic [63:0] f;
        int idx;
        cur_scl = scl;
        cur_sda = sda;
        if (s_prev_scl && cur_scl && s_prev_sda && !cur_sda) begin
            s_in = 1'b1; s_bitn = 0; s_acking = 1'b0; s_addressed = 1'b0;
            s_rx.delete(); s_bus_bytes = 0;
        end else if (s_prev_scl && cur_scl && !s_prev_sda && cur_sda) begin
            if (s_in && s_addressed && s_rx.size() >= 1) begin
                c = s_rx[0];
                nco_enable = c[0];
                nco_wave = c[2:1];
                idx = 1;
                if (c[4] && s_rx.size() >= idx + 8) begin
                    f = 64'h0;
                    for (int k = 0; k < 8; k++) f = {f[55:0], s_rx[idx + k]};
                    nco_freq = f;
                    idx += 8;
                end
                if (c[3] && s_rx.size() >= idx + 2) nco_duty = {s_rx[idx], s_rx[idx + 1]};
            end
            s_rx_last = s_rx.size();
            s_in = 1'b0;
        end else if (s_in && !s_prev_scl && cur_scl) begin
            if (s_bitn < 8) begin
                s_sh = {s_sh[6:0], cur_sda};
                s_bitn++;
            end
        end else if (s_in && s_prev_scl && !cur_scl) begin
            if (s_acking) begin
                slv_low <= 1'b0;
                s_acking = 1'b0;
                s_bitn = 0;
            end else if (s_bitn == 8) begin
                s_bus_bytes++;
                if (s_bus_bytes == 1) s_addressed = (s_sh == {slv_addr, 1'b0});
                else s_rx.push_back(s_sh);
                if (s_addressed) slv_low <= 1'b1;
                s_acking = 1'b1;
            end
        end
        s_prev_scl = cur_scl;
        s_prev_sda = cur_sda;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit ackv);
        for (int i = 7; i >= 0; i--) begin
            slot_kind.push_back(K_BIT);
            slot_val.push_back(b[i]);
        end
        slot_kind.push_back(K_ACK);
        slot_val.push_back(ackv);
    endtask

    task automatic run_txn(input logic [7:0] ctrl, input logic [63:0] freq, input logic [15:0] duty,
                           input bit match, input int exp_slots, input int inject_at, input int reset_at);
        int guard, limit;
        bit aborted;
        aborted = 1'b0;
        slv_addr = match ? 7'h75 : 7'h55;
        slot_kind.delete();
        slot_val.delete();
        slot_kind.push_back(K_START);
        slot_val.push_back(1'b0);
        push_byte(8'hEA, !match);
        nack_slot = match ? -1 : 9;
        if (match) begin
            push_byte(ctrl, 1'b0);
            if (ctrl[4]) for (int i = 7; i >= 0; i--) push_byte(freq[8*i +: 8], 1'b0);
            if (ctrl[3]) begin
                push_byte(duty[15:8], 1'b0);
                push_byte(duty[7:0], 1'b0);
            end
        end
        slot_kind.push_back(K_STOP);
        slot_val.push_back(1'b0);
        if (exp_slots > 0) chk("model_slots", 64'(slot_kind.size()), 64'(exp_slots));

        @(negedge clk); #1;
        cmd_ctrl = ctrl; cmd_freq = freq; cmd_duty = duty; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_ctrl = 8'($urandom); cmd_freq = {$urandom, $urandom}; cmd_duty = 16'($urandom);
        tcyc = 0;
        done_len = -1;
        mdl_active = 1'b1;
        limit = slot_kind.size() * SLOT_CLK + 20;
        guard = 0;
        while (mdl_active && guard < limit) begin
            if (tcyc == reset_at) begin
                chk_en = 1'b0;
                mdl_active = 1'b0;
                reset = 1'b0;
                @(posedge clk); #1;
                mdl_ack_err = 1'b0;
                chk("rst_scl", 64'(scl), 64'd1);
                chk("rst_sda", 64'(sda), 64'd1);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_ack_error", 64'(ack_error), 64'd0);
                chk_en = 1'b1;
                repeat (2) @(posedge clk);
                #1 reset = 1'b1;
                aborted = 1'b1;
            end else begin
                if (tcyc == inject_at) begin
                    cmd_valid = 1'b1;
                    cmd_ctrl = 8'($urandom); cmd_freq = {$urandom, $urandom}; cmd_duty = 16'($urandom);
                end else begin
                    cmd_valid = 1'b0;
                end
                @(posedge clk); #1;
                guard++;
            end
        end
        cmd_valid = 1'b0;
        if (!aborted) begin
            checks++;
            if (mdl_active) begin
                errors++;
                $display("FAIL timeout: transaction still open after %0d cycles, want done by %0d", guard, limit);
                mdl_active = 1'b0;
            end
            mdl_ack_err = !match;
            repeat (3) @(posedge clk); #1;
            chk("done_len", 64'(done_len),
                64'((exp_slots > 0 ? exp_slots : slot_kind.size()) * SLOT_CLK));
            chk("ack_error", 64'(ack_error), 64'(!match));
            if (match) begin
                chk("nco_enable", 64'(nco_enable), 64'(ctrl[0]));
                chk("nco_wave", 64'(nco_wave), 64'(ctrl[2:1]));
                if (ctrl[4]) chk("nco_freq", nco_freq, freq);
                if (ctrl[3]) chk("nco_duty", 64'(nco_duty), 64'(duty));
            end
        end
    endtask

    initial begin
        logic [63:0] f1, f2;
        logic [15:0] d1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("por_scl", 64'(scl), 64'd1);
        chk("por_busy", 64'(busy), 64'd0);
        chk("por_done", 64'(done), 64'd0);
        chk_en = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_txn(8'h05, 64'h0, 16'h0, 1'b1, 20, -1, -1);
        chk("t05_enable", 64'(nco_enable), 64'd1);
        chk("t05_wave", 64'(nco_wave), 64'd2);
        chk("t05_len", 64'(done_len), 64'd400);
        chk("t05_rx_bytes", 64'(s_rx_last), 64'd1);

        run_txn(8'h15, 64'h0001D4C0_00000000, 16'h1234, 1'b1, 92, -1, -1);
        chk("t15_freq", nco_freq, 64'h0001D4C0_00000000);
        chk("t15_rx_bytes", 64'(s_rx_last), 64'd9);
        chk("t15_len", 64'(done_len), 64'd1840);

        run_txn(8'h0D, 64'hFFFF_0000_AAAA_5555, 16'h8000, 1'b1, 38, -1, -1);
        chk("t0d_duty", 64'(nco_duty), 64'h8000);
        chk("t0d_freq_kept", nco_freq, 64'h0001D4C0_00000000);
        chk("t0d_rx_bytes", 64'(s_rx_last), 64'd3);

        f1 = 64'h0123_4567_89AB_CDEF;
        d1 = 16'h4321;
        run_txn(8'h1D, f1, d1, 1'b1, 110, -1, -1);
        chk("t1d_freq", nco_freq, 64'h0123_4567_89AB_CDEF);
        chk("t1d_duty", 64'(nco_duty), 64'h4321);
        chk("t1d_len", 64'(done_len), 64'd2200);

        run_txn(8'h05, 64'h0, 16'h0, 1'b0, 11, -1, -1);
        chk("nack_ack_error", 64'(ack_error), 64'd1);
        chk("nack_bus_bytes", 64'(s_bus_bytes), 64'd1);
        chk("nack_len", 64'(done_len), 64'd220);

        run_txn(8'h01, 64'h0, 16'h0, 1'b1, 20, -1, -1);
        chk("clear_ack_error", 64'(ack_error), 64'd0);

        f2 = 64'hDEAD_BEEF_0BAD_F00D;
        run_txn(8'h15, f2, 16'h0, 1'b1, 92, 300, -1);
        chk("busy_ignored_freq", nco_freq, 64'hDEAD_BEEF_0BAD_F00D);
        run_txn(8'h0D, 64'h0, 16'h7F01, 1'b1, 38, 38 * SLOT_CLK - 1, -1);
        chk("done_cycle_ignored", 64'(busy), 64'd0);

        run_txn(8'h15, 64'h1111_2222_3333_4444, 16'h0, 1'b1, 92, -1, 605);
        run_txn(8'h05, 64'h0, 16'h0, 1'b1, 20, -1, -1);
        chk("post_reset_freq_kept", nco_freq, 64'hDEAD_BEEF_0BAD_F00D);

        for (int n = 0; n < 12; n++) begin
            logic [7:0] rc;
            bit rm;
            int inj;
            rc = 8'($urandom_range(0, 255));
            rm = ($urandom_range(0, 3) != 0);
            inj = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 300) : -1;
            run_txn(rc, {$urandom, $urandom}, 16'($urandom), rm, 0, inj, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
